// File: rtl/smc_seq.sv
// smc_seq: serial MOSFET current/gm sorter.
// Emits a plain or rank-weighted sum of the K extreme values per transaction.
module smc_seq #(
   parameter  int CH_NUM = 6,
   parameter  int DW     = 3,
   parameter  int K      = 3,
   localparam int VW     = 3*DW+1,
   localparam int OW     = VW+$clog2(K*(K+1)/2+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] W,
   input  logic [DW-1:0] V_GS,
   input  logic [DW-1:0] V_DS,
   input  logic [1:0]    mode,
   output logic          out_valid,
   output logic [OW-1:0] out_n
);

   localparam int IW = VW+1;
   localparam int CW = $clog2(CH_NUM+1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CALC,
      S_OUT
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_mode;
   logic [VW-1:0]   r_arr [CH_NUM];
   logic            r_out_valid;
   logic [OW-1:0]   r_out_n;

   logic [IW-1:0]   w_vov;
   logic [IW-1:0]   w_vds;
   logic [IW-1:0]   w_w;
   logic [IW-1:0]   w_cur;
   logic [IW-1:0]   w_gm;
   logic            w_isel;
   logic [VW-1:0]   w_val;
   logic [CH_NUM-1:0] w_ge;
   logic [VW-1:0]   w_nxt [CH_NUM];
   logic [CW-1:0]   w_cnt_inc;
   logic [VW-1:0]   w_pick;
   logic [OW-1:0]   w_sum;

   // Per-channel I or gm of the incoming descriptor; mode bit 0 is live on the first sample only
   always_comb begin
      w_vov = IW'(V_GS) - IW'(1);
      w_vds = IW'(V_DS);
      w_w   = IW'(W);
      w_cur = '0;
      w_gm  = '0;
      if (V_GS > DW'(1)) begin
         if (w_vov > w_vds) begin
            w_cur = w_w * (IW'(2)*w_vov*w_vds - w_vds*w_vds) / IW'(3);
            w_gm  = IW'(2) * w_w * w_vds / IW'(3);
         end else begin
            w_cur = w_w * w_vov * w_vov / IW'(3);
            w_gm  = IW'(2) * w_w * w_vov / IW'(3);
         end
      end
      w_isel = (r_state == S_IDLE) ? mode[0] : r_mode[0];
      w_val  = w_isel ? VW'(w_cur) : VW'(w_gm);
   end

   // Single-cycle insertion: keep entries >= new value, drop it in, shift the rest down
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         w_ge[i] = (i < int'(r_cnt)) && (r_arr[i] >= w_val);
      end
      w_nxt[0] = w_ge[0] ? r_arr[0] : w_val;
      for (int i = 1; i < CH_NUM; i++) begin
         if (w_ge[i])
            w_nxt[i] = r_arr[i];
         else if (w_ge[i-1])
            w_nxt[i] = w_val;
         else
            w_nxt[i] = r_arr[i-1];
      end
      w_cnt_inc = r_cnt + CW'(1);
   end

   // Extreme-first selection of K entries, weighted K..1 when summing currents
   always_comb begin
      w_sum  = '0;
      w_pick = '0;
      for (int k = 0; k < K; k++) begin
         w_pick = r_mode[1] ? r_arr[k] : r_arr[CH_NUM-1-k];
         w_sum  = w_sum + OW'(w_pick) * (r_mode[0] ? OW'(K-k) : OW'(1));
      end
   end

   // Transaction FSM with registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mode      <= '0;
         r_out_valid <= 1'b0;
         r_out_n     <= '0;
         for (int i = 0; i < CH_NUM; i++) r_arr[i] <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_arr   <= w_nxt;
                  r_cnt   <= CW'(1);
                  r_mode  <= mode;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  r_arr <= w_nxt;
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == CW'(CH_NUM)) r_state <= S_CALC;
               end else begin
                  for (int i = 0; i < CH_NUM; i++) r_arr[i] <= '0;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               r_out_n     <= w_sum;
               r_out_valid <= 1'b1;
               r_state     <= S_OUT;
            end
            S_OUT: begin
               r_out_n     <= '0;
               r_out_valid <= 1'b0;
               r_cnt       <= '0;
               for (int i = 0; i < CH_NUM; i++) r_arr[i] <= '0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_n     = r_out_n;

endmodule

// File: tb/tb_smc_seq.sv
// tb_smc_seq: directed bench for smc_seq.
// Default instance plus a CH_NUM=8, K=4 instance.
module tb_smc_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv = 1'b0;
   logic        iv8 = 1'b0;
   logic [2:0]  w = '0;
   logic [2:0]  vgs = '0;
   logic [2:0]  vds = '0;
   logic [1:0]  md = '0;
   logic        ov;
   logic [12:0] on;
   logic        ov8;
   logic [13:0] on8;

   int n_cmp = 0;
   int n_err = 0;

   logic [2:0] tw [8];
   logic [2:0] tg [8];
   logic [2:0] td [8];

   always #5 clk = ~clk;

   smc_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv),
      .W(w), .V_GS(vgs), .V_DS(vds), .mode(md),
      .out_valid(ov), .out_n(on)
   );

   smc_seq #(.CH_NUM(8), .DW(3), .K(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8),
      .W(w), .V_GS(vgs), .V_DS(vds), .mode(md),
      .out_valid(ov8), .out_n(on8)
   );

   task automatic load_s();
      tw = '{3'd7, 3'd3, 3'd6, 3'd1, 3'd2, 3'd5, 3'd4, 3'd1};
      tg = '{3'd7, 3'd4, 3'd5, 3'd0, 3'd3, 3'd7, 3'd6, 3'd2};
      td = '{3'd7, 3'd1, 3'd4, 3'd5, 3'd1, 3'd2, 3'd6, 3'd0};
   endtask

   // Drive n samples; returns #1 into cycle t+1 with in_valid low.
   task automatic send(input int n, input logic [1:0] m,
                       input bit big, input bit tog);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (big) iv8 = 1'b1; else iv = 1'b1;
         w   = tw[i];
         vgs = tg[i];
         vds = td[i];
         md  = (tog && i > 0) ? ~m : m;
      end
      @(posedge clk); #1;
      iv  = 1'b0;
      iv8 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (ov !== 1'b0 || on !== 13'd0) begin
         n_err++;
         $display("FAIL reset: out_valid=%0b out_n=%0d, wanted 0/0", ov, on);
      end
      n_cmp++;
      if (ov8 !== 1'b0 || on8 !== 14'd0) begin
         n_err++;
         $display("FAIL reset8: out_valid=%0b out_n=%0d, wanted 0/0", ov8, on8);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_main();
      logic [1:0]  ms [2];
      logic [12:0] ex [2];
      ms = '{2'b11, 2'b01};
      ex = '{13'd350, 13'd9};
      load_s();
      for (int j = 0; j < 2; j++) begin
         send(6, ms[j], 1'b0, 1'b0);
         n_cmp++;
         if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL main_t1[%0d]: out_valid=%0b, wanted 0", j, ov);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (ov !== 1'b1 || on !== ex[j]) begin
            n_err++;
            $display("FAIL main[%0d]: out_valid=%0b out_n=%0d, wanted 1/%0d",
                     j, ov, on, ex[j]);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (ov !== 1'b0 || on !== 13'd0) begin
            n_err++;
            $display("FAIL main_t3[%0d]: out_valid=%0b out_n=%0d, wanted 0/0",
                     j, ov, on);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  ms [4];
      logic [12:0] ex [4];
      ms = '{2'b11, 2'b01, 2'b10, 2'b00};
      ex = '{13'd350, 13'd9, 13'd50, 13'd3};
      load_s();
      for (int j = 0; j < 4; j++) begin
         send(6, ms[j], 1'b0, 1'b0);
         @(posedge clk); #1;
         n_cmp++;
         if (ov !== 1'b1 || on !== ex[j]) begin
            n_err++;
            $display("FAIL b2b[%0d]: out_valid=%0b out_n=%0d, wanted 1/%0d",
                     j, ov, on, ex[j]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int seen;
      load_s();
      send(4, 2'b11, 1'b0, 1'b0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (ov !== 1'b0) seen++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL abort_quiet: out_valid cycles=%0d, wanted 0", seen);
      end
      send(6, 2'b11, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== 1'b1 || on !== 13'd350) begin
         n_err++;
         $display("FAIL abort_next: out_valid=%0b out_n=%0d, wanted 1/350",
                  ov, on);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      load_s();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         iv  = 1'b1;
         w   = tw[i];
         vgs = tg[i];
         vds = td[i];
         md  = 2'b11;
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (ov !== 1'b0 || on !== 13'd0) begin
         n_err++;
         $display("FAIL rst_mid: out_valid=%0b out_n=%0d, wanted 0/0", ov, on);
      end
      iv = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(6, 2'b01, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== 1'b1 || on !== 13'd9) begin
         n_err++;
         $display("FAIL rst_next: out_valid=%0b out_n=%0d, wanted 1/9", ov, on);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_boundary();
      for (int i = 0; i < 8; i++) begin
         tw[i] = 3'd7; tg[i] = 3'd7; td[i] = 3'd7;
      end
      send(6, 2'b01, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== 1'b1 || on !== 13'd504) begin
         n_err++;
         $display("FAIL all_max: out_valid=%0b out_n=%0d, wanted 1/504", ov, on);
      end
      for (int i = 0; i < 8; i++) begin
         tw[i] = 3'(i + 1); tg[i] = 3'd1; td[i] = 3'(7 - i);
      end
      send(6, 2'b11, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== 1'b1 || on !== 13'd0) begin
         n_err++;
         $display("FAIL cutoff11: out_valid=%0b out_n=%0d, wanted 1/0", ov, on);
      end
      send(6, 2'b00, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== 1'b1 || on !== 13'd0) begin
         n_err++;
         $display("FAIL cutoff00: out_valid=%0b out_n=%0d, wanted 1/0", ov, on);
      end
      load_s();
      send(6, 2'b11, 1'b0, 1'b1);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== 1'b1 || on !== 13'd350) begin
         n_err++;
         $display("FAIL mode_tog: out_valid=%0b out_n=%0d, wanted 1/350", ov, on);
      end
      send(6, 2'b00, 1'b0, 1'b1);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== 1'b1 || on !== 13'd3) begin
         n_err++;
         $display("FAIL mode_tog00: out_valid=%0b out_n=%0d, wanted 1/3", ov, on);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_variant();
      logic [1:0]  ms [2];
      logic [13:0] ex [2];
      ms = '{2'b11, 2'b01};
      ex = '{14'd533, 14'd9};
      load_s();
      for (int j = 0; j < 2; j++) begin
         send(8, ms[j], 1'b1, 1'b0);
         n_cmp++;
         if (ov8 !== 1'b0 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL var_t1[%0d]: out_valid8=%0b out_valid=%0b, wanted 0/0",
                     j, ov8, ov);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (ov8 !== 1'b1 || on8 !== ex[j]) begin
            n_err++;
            $display("FAIL var[%0d]: out_valid=%0b out_n=%0d, wanted 1/%0d",
                     j, ov8, on8, ex[j]);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_main();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_boundary();
      test_variant();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
